// File: rtl/axi4_lite_gpu_fill_if.sv
// axi4_lite_gpu_fill_if: AXI4-Lite control bus bundle for the fill engine.
interface axi4_lite_gpu_fill_if #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32
);
  logic [AXI_ADDRESS_WIDTH-1:0] araddr;
  logic                         arvalid;
  logic                         arready;
  logic [AXI_DATA_WIDTH-1:0]    rdata;
  logic [1:0]                   rresp;
  logic                         rvalid;
  logic                         rready;
  logic [AXI_ADDRESS_WIDTH-1:0] awaddr;
  logic                         awvalid;
  logic                         awready;
  logic [AXI_DATA_WIDTH-1:0]    wdata;
  logic                         wvalid;
  logic                         wready;
  logic [1:0]                   bresp;
  logic                         bvalid;
  logic                         bready;
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi4_lite_gpu_fill.sv
// axi4_lite_gpu_fill: AXI4-Lite controlled rectangle / full-screen fill engine writing one pixel per cycle to a framebuffer BRAM.
module axi4_lite_gpu_fill #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int FBUF_ADDR_WIDTH   = 19,
  parameter int FBUF_DATA_WIDTH   = 8,
  parameter int FB_WIDTH          = 640,
  parameter int FB_HEIGHT         = 480
) (
  input  logic                       s_axi_ctrl_aclk,
  input  logic                       s_axi_ctrl_areset,
  axi4_lite_gpu_fill_if.slave        s_axi_ctrl,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
  output logic                       irq
);
  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;
  localparam logic [16:0] FBW = 17'(FB_WIDTH);
  localparam logic [16:0] FBH = 17'(FB_HEIGHT);

  state_t state_q, state_d;
  logic aw_rdy_q, aw_rdy_d, ar_rdy_q, ar_rdy_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_val;
  logic mode_q, mode_d, irq_en_q, irq_en_d, done_q, done_d;
  logic [31:0] pos_q, pos_d, size_q, size_d;
  logic [FBUF_DATA_WIDTH-1:0] color_q, color_d;
  logic [16:0] cx_q, cx_d, cy_q, cy_d, x0_q, x0_d, xe_q, xe_d, ye_q, ye_d;
  logic [16:0] sx, sy, sw, sh;
  logic [2:0] w_off, r_off;
  logic hs_w, hs_r, busy, w_err, r_bad, wr_ok, start, last_x, last_y, run, clip;
  logic [47:0] pix;
  logic unused_bits;

  always_comb begin
    hs_w     = aw_rdy_q & s_axi_ctrl.awvalid & s_axi_ctrl.wvalid;
    hs_r     = ar_rdy_q & s_axi_ctrl.arvalid;
    busy     = state_q != IDLE;
    w_off    = s_axi_ctrl.awaddr[4:2];
    r_off    = s_axi_ctrl.araddr[4:2];
    r_bad    = (|(s_axi_ctrl.araddr >> 5)) | (r_off > 3'd4);
    // Parameter writes and re-START are refused while a fill owns the registers.
    w_err    = (|(s_axi_ctrl.awaddr >> 5)) | (w_off > 3'd4) |
               (busy & ((w_off >= 3'd2) | (w_off == 3'd0 & s_axi_ctrl.wdata[0])));
    wr_ok    = hs_w & ~w_err;
    start    = wr_ok & (w_off == 3'd0) & s_axi_ctrl.wdata[0];
    sx       = s_axi_ctrl.wdata[1] ? 17'd0 : {1'b0, pos_q[15:0]};
    sy       = s_axi_ctrl.wdata[1] ? 17'd0 : {1'b0, pos_q[31:16]};
    sw       = s_axi_ctrl.wdata[1] ? FBW : {1'b0, size_q[15:0]};
    sh       = s_axi_ctrl.wdata[1] ? FBH : {1'b0, size_q[31:16]};
    rd_val   = r_off == 3'd0 ? AXI_DATA_WIDTH'({irq_en_q, mode_q, 1'b0}) :
               r_off == 3'd1 ? AXI_DATA_WIDTH'({done_q, busy}) :
               r_off == 3'd2 ? AXI_DATA_WIDTH'(pos_q) :
               r_off == 3'd3 ? AXI_DATA_WIDTH'(size_q) : AXI_DATA_WIDTH'(color_q);
    aw_rdy_d = s_axi_ctrl.awvalid & s_axi_ctrl.wvalid & ~bvalid_q & ~aw_rdy_q;
    bvalid_d = hs_w | (bvalid_q & ~s_axi_ctrl.bready);
    bresp_d  = hs_w ? {w_err, 1'b0} : bresp_q;
    ar_rdy_d = s_axi_ctrl.arvalid & ~rvalid_q & ~ar_rdy_q;
    rvalid_d = hs_r | (rvalid_q & ~s_axi_ctrl.rready);
    rresp_d  = hs_r ? {r_bad, 1'b0} : rresp_q;
    rdata_d  = hs_r ? (r_bad ? '0 : rd_val) : rdata_q;
    mode_d   = wr_ok & (w_off == 3'd0) ? s_axi_ctrl.wdata[1] : mode_q;
    irq_en_d = wr_ok & (w_off == 3'd0) ? s_axi_ctrl.wdata[2] : irq_en_q;
    pos_d    = wr_ok & (w_off == 3'd2) ? s_axi_ctrl.wdata[31:0] : pos_q;
    size_d   = wr_ok & (w_off == 3'd3) ? s_axi_ctrl.wdata[31:0] : size_q;
    color_d  = wr_ok & (w_off == 3'd4) ? s_axi_ctrl.wdata[FBUF_DATA_WIDTH-1:0] : color_q;
    // Completion set has priority over a coincident write-1-to-clear.
    done_d   = (state_q == DONE_ST) | (done_q & ~(wr_ok & (w_off == 3'd1) & s_axi_ctrl.wdata[1]));
    last_x   = cx_q + 17'd1 == xe_q;
    last_y   = cy_q + 17'd1 == ye_q;
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x0_d     = x0_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    if (state_q == IDLE && start) begin
      state_d = (~s_axi_ctrl.wdata[1] & (sw == 17'd0 | sh == 17'd0)) ? DONE_ST : RUN;
      cx_d    = sx;
      cy_d    = sy;
      x0_d    = sx;
      xe_d    = sx + sw;
      ye_d    = sy + sh;
    end else if (state_q == RUN) begin
      cx_d    = last_x ? x0_q : cx_q + 17'd1;
      cy_d    = last_x ? cy_q + 17'd1 : cy_q;
      state_d = last_x & last_y ? DONE_ST : RUN;
    end else if (state_q == DONE_ST) begin
      state_d = IDLE;
    end
    run         = state_q == RUN;
    clip        = (cx_q >= FBW) | (cy_q >= FBH);
    pix         = 48'(cy_q) * 48'(FB_WIDTH) + 48'(cx_q);
    fbuf_en_wr  = run & ~clip;
    fbuf_wrea   = run & ~clip;
    fbuf_addr   = run ? pix[FBUF_ADDR_WIDTH-1:0] : '0;
    fbuf_data   = run ? color_q : '0;
    irq         = done_q & irq_en_q;
    unused_bits = &{1'b0, s_axi_ctrl.awaddr[1:0], s_axi_ctrl.araddr[1:0], pix[47:FBUF_ADDR_WIDTH]};
  end

  assign s_axi_ctrl.awready = aw_rdy_q;
  assign s_axi_ctrl.wready  = aw_rdy_q;
  assign s_axi_ctrl.bvalid  = bvalid_q;
  assign s_axi_ctrl.bresp   = bresp_q;
  assign s_axi_ctrl.arready = ar_rdy_q;
  assign s_axi_ctrl.rvalid  = rvalid_q;
  assign s_axi_ctrl.rresp   = rresp_q;
  assign s_axi_ctrl.rdata   = rdata_q;

  always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_areset) begin
    if (s_axi_ctrl_areset) begin
      state_q  <= IDLE;
      aw_rdy_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
      mode_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      pos_q    <= '0;
      size_q   <= '0;
      color_q  <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x0_q     <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
    end else begin
      state_q  <= state_d;
      aw_rdy_q <= aw_rdy_d;
      ar_rdy_q <= ar_rdy_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      mode_q   <= mode_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      pos_q    <= pos_d;
      size_q   <= size_d;
      color_q  <= color_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x0_q     <= x0_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
    end
  end
endmodule
